led_sequencer: RTL

Memory-mapped controller that owns the board LED register and sequences it autonomously: static display, blink, or rotate, paced by a programmable prescaler. It sits on the CPU's peripheral bus in place of a plain LED latch. It arbitrates between CPU writes and its own step engine, and raises a level interrupt on each step when enabled.

---
 rtl/led_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// LED register controller: holds a 32-bit pattern and shows it static, blinking,
// or rotating, one step per PERIOD+1 cycles, with a sticky step flag and level irq.
module led_sequencer #(
    parameter int CNT_W  = 32,
    parameter int STEP_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  Addr,
    input  logic [31:0] DIn,
    input  logic        WE,
    output logic [31:0] RD,
    output logic [31:0] led_light,
    output logic        irq
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_ROL    = 2'b10,
        MODE_ROR    = 2'b11
    } mode_e;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_PERIOD = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic [31:0]       pattern_q,  pattern_d;
    mode_e             mode_q,     mode_d;
    logic              en_q,       en_d;
    logic              irq_en_q,   irq_en_d;
    logic [CNT_W-1:0]  period_q,   period_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              phase_q,    phase_d;
    logic              flag_q,     flag_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [31:0]       led_q,      led_d;
    logic              irq_q,      irq_d;

    logic wr_data, wr_ctrl, wr_period, wr_status;
    logic active, step, restart;

    assign wr_data   = WE && (Addr == A_DATA);
    assign wr_ctrl   = WE && (Addr == A_CTRL);
    assign wr_period = WE && (Addr == A_PERIOD);
    assign wr_status = WE && (Addr == A_STATUS);

    assign active  = en_q && (mode_q != MODE_STATIC);
    assign step    = active && (cnt_q == '0);
    assign restart = wr_ctrl || wr_period;

    always_comb begin
        pattern_d  = pattern_q;
        mode_d     = mode_q;
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        period_d   = period_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        flag_d     = flag_q;
        step_cnt_d = step_cnt_q;
        led_d      = led_q;
        irq_d      = irq_q;

        if (wr_ctrl) begin
            mode_d   = mode_e'(DIn[1:0]);
            en_d     = DIn[2];
            irq_en_d = DIn[3];
        end
        if (wr_period)
            period_d = DIn[CNT_W-1:0];

        // A CTRL/PERIOD write restarts the prescaler from the (possibly new) period.
        if (restart)
            cnt_d = period_d;
        else if (step)
            cnt_d = period_q;
        else if (active)
            cnt_d = cnt_q - CNT_W'(1);

        // CPU data write beats the step engine's pattern/phase update.
        if (wr_data) begin
            pattern_d = DIn;
        end else if (step) begin
            case (mode_q)
                MODE_ROL: pattern_d = {pattern_q[30:0], pattern_q[31]};
                MODE_ROR: pattern_d = {pattern_q[0], pattern_q[31:1]};
                default:  pattern_d = pattern_q;
            endcase
        end

        if (wr_data || restart)
            phase_d = 1'b0;
        else if (step && mode_q == MODE_BLINK)
            phase_d = ~phase_q;

        // Step set has priority over the write-1-to-clear.
        if (step)
            flag_d = 1'b1;
        else if (wr_status && DIn[0])
            flag_d = 1'b0;

        if (step)
            step_cnt_d = step_cnt_q + STEP_W'(1);

        led_d = (mode_d == MODE_BLINK && phase_d) ? 32'd0 : pattern_d;
        irq_d = flag_q & irq_en_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q  <= '0;
            mode_q     <= MODE_STATIC;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            period_q   <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            flag_q     <= 1'b0;
            step_cnt_q <= '0;
            led_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            pattern_q  <= pattern_d;
            mode_q     <= mode_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            flag_q     <= flag_d;
            step_cnt_q <= step_cnt_d;
            led_q      <= led_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        RD = 32'd0;
        if (reset_n) begin
            case (Addr)
                A_DATA:   RD = led_q;
                A_CTRL:   RD = {28'd0, irq_en_q, en_q, mode_q};
                A_PERIOD: RD = 32'(period_q);
                A_STATUS: RD = {16'(step_cnt_q), 15'd0, flag_q};
                default:  RD = 32'd0;
            endcase
        end
    end

    assign led_light = led_q;
    assign irq       = irq_q;

endmodule
